// File: rtl/rbt_s_hdr_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rbt_s_hdr_rr_arbiter_pkg
//   Shared constants and types for the header round-robin arbiter.
//   HDR_LEN_WIDTH is the proto-header length field width. It is also used by
//   the rbt_s_*_parser stages that sit behind the arbiter.
// ---------------------------------------------------------------------------
package rbt_s_hdr_rr_arbiter_pkg;

  // Width of the per-header length field carried alongside every header.
  localparam int HDR_LEN_WIDTH = 16;

  typedef logic [HDR_LEN_WIDTH-1:0] hdr_len_t;

  // Source-port index width for a given number of requesters.
  // A single requester still gets a 1-bit index.
  function automatic int sel_width(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/rbt_s_rr_pick.sv
// ---------------------------------------------------------------------------
// rbt_s_rr_pick
//   Purely combinational round-robin pick. Among the requesters at or above
//   ptr, the lowest-numbered one wins. If none of those is requesting, the
//   search wraps and the lowest-numbered requester overall wins.
//
// Ports
//   req        in   PORTS      request vector (valid & enable)
//   ptr        in   SEL_WIDTH  round-robin start position, always < PORTS
//   grant      out  PORTS      one-hot grant, or zero when nothing requests
//   grant_idx  out  SEL_WIDTH  binary index of the granted port (0 if none)
//   grant_any  out  1          at least one requester present
// ---------------------------------------------------------------------------
module rbt_s_rr_pick
  import rbt_s_hdr_rr_arbiter_pkg::*;
#(
  parameter int PORTS     = 4,
  parameter int SEL_WIDTH = sel_width(PORTS)
) (
  input  logic [PORTS-1:0]     req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [PORTS-1:0]     grant,
  output logic [SEL_WIDTH-1:0] grant_idx,
  output logic                 grant_any
);

  logic [PORTS-1:0] lo_mask;
  logic [PORTS-1:0] req_hi;
  logic [PORTS-1:0] first_hi;
  logic [PORTS-1:0] first_all;

  // Bits strictly below ptr form the "already served" half of the ring.
  assign lo_mask = (PORTS'(1) << ptr) - PORTS'(1);
  assign req_hi  = req & ~lo_mask;

  // x & -x isolates the lowest set bit. Searching the upper half first and
  // then falling back to the full vector gives the wrapping scan without a
  // PORTS-deep priority chain.
  assign first_hi  = req_hi & (~req_hi + PORTS'(1));
  assign first_all = req & (~req + PORTS'(1));

  assign grant     = (|req_hi) ? first_hi : first_all;
  assign grant_any = |req;

  // One-hot to binary: index bit gb is the OR of the grants whose port
  // number has bit gb set.
  genvar gi, gb;
  generate
    for (gb = 0; gb < SEL_WIDTH; gb++) begin : g_idx_bit
      logic [PORTS-1:0] has_bit;
      for (gi = 0; gi < PORTS; gi++) begin : g_port
        assign has_bit[gi] = (((gi >> gb) & 1) != 0);
      end
      assign grant_idx[gb] = |(grant & has_bit);
    end
  endgenerate

endmodule

// File: rtl/rbt_s_hdr_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rbt_s_hdr_rr_arbiter
//   Round-robin arbiter that shares one proto-header parser chain between
//   PORTS ingress header streams. One header+PHV+length beat per cycle is
//   moved into a single output register. Each beat is tagged with the index
//   of the port that supplied it. Header, PHV and length pass through
//   unmodified.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_proto_hdr_valid       PORTS            per-port valid
//   in_proto_hdr_ready       PORTS            per-port ready (grant & can_load)
//   in_proto_hdr_length      PORTS*16         port i at [i*16 +: 16]
//   in_proto_hdr_data        PORTS*HEADER_W   port i at [i*HEADER_WIDTH +: HEADER_WIDTH]
//   in_proto_hdr_phv         PORTS*PHV_W      port i at [i*PHV_WIDTH +: PHV_WIDTH]
//   cfg_port_enable          PORTS            1 = port may be granted
//   cfg_cnt_clear            1                pulse, clears every accept counter
//   out_proto_hdr_valid      1                registered output valid
//   out_proto_hdr_ready      1                downstream ready
//   out_proto_hdr_data/phv/length             granted beat
//   out_proto_hdr_src        SEL_WIDTH        port index of the output beat
//   stat_accept_cnt          PORTS*CNT_WIDTH  per-port accepted-header counts
// ---------------------------------------------------------------------------
module rbt_s_hdr_rr_arbiter
  import rbt_s_hdr_rr_arbiter_pkg::*;
#(
  parameter int PORTS        = 4,
  parameter int HEADER_WIDTH = 2048,
  parameter int PHV_WIDTH    = 408,
  parameter int CNT_WIDTH    = 32,
  parameter int SEL_WIDTH    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORTS-1:0]             in_proto_hdr_valid,
  output logic [PORTS-1:0]             in_proto_hdr_ready,
  input  logic [PORTS*16-1:0]          in_proto_hdr_length,
  input  logic [PORTS*HEADER_WIDTH-1:0] in_proto_hdr_data,
  input  logic [PORTS*PHV_WIDTH-1:0]   in_proto_hdr_phv,
  input  logic [PORTS-1:0]             cfg_port_enable,
  input  logic                         cfg_cnt_clear,
  output logic                         out_proto_hdr_valid,
  input  logic                         out_proto_hdr_ready,
  output logic [HEADER_WIDTH-1:0]      out_proto_hdr_data,
  output logic [PHV_WIDTH-1:0]         out_proto_hdr_phv,
  output logic [15:0]                  out_proto_hdr_length,
  output logic [SEL_WIDTH-1:0]         out_proto_hdr_src,
  output logic [PORTS*CNT_WIDTH-1:0]   stat_accept_cnt
);

  // Header, PHV and length travel together as one payload word so that a
  // single AND-OR mux and a single register cover all three.
  localparam int PW = HEADER_WIDTH + PHV_WIDTH + HDR_LEN_WIDTH;

  logic [PORTS-1:0]     req;
  logic [PORTS-1:0]     grant;
  logic [SEL_WIDTH-1:0] grant_idx;
  logic                 grant_any;
  logic                 can_load;
  logic                 accept;

  logic                 out_valid_reg;
  logic [PW-1:0]        out_payload_reg;
  logic [SEL_WIDTH-1:0] out_src_reg;
  logic [SEL_WIDTH-1:0] rr_ptr_reg;
  logic [SEL_WIDTH-1:0] rr_ptr_next;

  logic [PORTS*PW-1:0]  payload_flat;
  logic [PW-1:0]        payload_mux;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  assign req = in_proto_hdr_valid & cfg_port_enable;

  rbt_s_rr_pick #(
    .PORTS     (PORTS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_pick (
    .req       (req),
    .ptr       (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // The output register can take a new beat when it is empty or is being
  // drained this cycle. Ready is held low while reset is asserted.
  assign can_load           = ~out_valid_reg | out_proto_hdr_ready;
  assign in_proto_hdr_ready = grant & {PORTS{can_load & ~rst}};
  assign accept             = grant_any & can_load & ~rst;

  // The pointer moves to one past the winner and wraps at PORTS-1.
  // With PORTS=1 both sides of the compare are 0, so the pointer stays 0.
  assign rr_ptr_next = (grant_idx == SEL_WIDTH'(PORTS - 1)) ? '0
                                                            : grant_idx + SEL_WIDTH'(1);

  // -------------------------------------------------------------------------
  // Payload mux: AND-OR over the one-hot grant. Each output bit is reduced
  // independently, which keeps the logic shallow for very wide headers.
  // -------------------------------------------------------------------------
  genvar gi, gb;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_port_payload
      assign payload_flat[gi*PW +: PW] = {
        in_proto_hdr_length[gi*HDR_LEN_WIDTH +: HDR_LEN_WIDTH],
        in_proto_hdr_phv[gi*PHV_WIDTH +: PHV_WIDTH],
        in_proto_hdr_data[gi*HEADER_WIDTH +: HEADER_WIDTH]
      };
    end

    for (gb = 0; gb < PW; gb++) begin : g_mux_bit
      logic [PORTS-1:0] col;
      for (gi = 0; gi < PORTS; gi++) begin : g_port
        assign col[gi] = payload_flat[gi*PW + gb];
      end
      assign payload_mux[gb] = |(col & grant);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Output register and round-robin pointer. The register loads only on
  // accept, so the outputs hold while valid & ~ready. A drain with no
  // accept empties the register. Reset discards any in-flight beat.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg   <= 1'b0;
      out_payload_reg <= '0;
      out_src_reg     <= '0;
      rr_ptr_reg      <= '0;
    end else if (accept) begin
      out_valid_reg   <= 1'b1;
      out_payload_reg <= payload_mux;
      out_src_reg     <= grant_idx;
      rr_ptr_reg      <= rr_ptr_next;
    end else if (out_proto_hdr_ready) begin
      out_valid_reg   <= 1'b0;
    end
  end

  assign out_proto_hdr_valid  = out_valid_reg;
  assign out_proto_hdr_data   = out_payload_reg[0 +: HEADER_WIDTH];
  assign out_proto_hdr_phv    = out_payload_reg[HEADER_WIDTH +: PHV_WIDTH];
  assign out_proto_hdr_length = out_payload_reg[HEADER_WIDTH+PHV_WIDTH +: HDR_LEN_WIDTH];
  assign out_proto_hdr_src    = out_src_reg;

  // -------------------------------------------------------------------------
  // Per-port accept counters. When clear and an increment land in the same
  // cycle, clear wins and that increment is lost. The counters wrap
  // naturally at 2^CNT_WIDTH.
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst || cfg_cnt_clear) begin
          cnt_reg <= '0;
        end else if (accept && grant[gi]) begin
          cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        end
      end
      assign stat_accept_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
    end
  endgenerate

endmodule

// File: tb/tb_rbt_s_hdr_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rbt_s_hdr_rr_arbiter
//   Self-checking bench. A reference model of the arbiter predicts
//   in_ready every cycle. Each accepted beat is pushed onto a scoreboard
//   queue, which is checked against the output register until that beat
//   drains. A vector table covers rotation and port masking. Hand-written
//   sequences cover stall, counter wrap/clear, reset and PORTS=1.
// ---------------------------------------------------------------------------
module tb_rbt_s_hdr_rr_arbiter;

  localparam int P   = 4;
  localparam int HW  = 64;
  localparam int PHW = 16;
  localparam int CW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [P-1:0]      in_valid, in_ready, enable;
  logic [P*16-1:0]   in_len;
  logic [P*HW-1:0]   in_data;
  logic [P*PHW-1:0]  in_phv;
  logic              clear, out_valid, out_ready;
  logic [HW-1:0]     out_data;
  logic [PHW-1:0]    out_phv;
  logic [15:0]       out_len;
  logic [1:0]        out_src;
  logic [P*CW-1:0]   stat;

  // Single-port instance
  logic              p1_valid, p1_ready, p1_enable, p1_out_valid, p1_out_ready;
  logic [15:0]       p1_len, p1_out_len;
  logic [HW-1:0]     p1_data, p1_out_data;
  logic [PHW-1:0]    p1_phv, p1_out_phv;
  logic [0:0]        p1_out_src;
  logic [CW-1:0]     p1_stat;

  rbt_s_hdr_rr_arbiter #(.PORTS(P), .HEADER_WIDTH(HW), .PHV_WIDTH(PHW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_proto_hdr_valid(in_valid), .in_proto_hdr_ready(in_ready),
    .in_proto_hdr_length(in_len), .in_proto_hdr_data(in_data), .in_proto_hdr_phv(in_phv),
    .cfg_port_enable(enable), .cfg_cnt_clear(clear),
    .out_proto_hdr_valid(out_valid), .out_proto_hdr_ready(out_ready),
    .out_proto_hdr_data(out_data), .out_proto_hdr_phv(out_phv),
    .out_proto_hdr_length(out_len), .out_proto_hdr_src(out_src),
    .stat_accept_cnt(stat)
  );

  rbt_s_hdr_rr_arbiter #(.PORTS(1), .HEADER_WIDTH(HW), .PHV_WIDTH(PHW), .CNT_WIDTH(CW)) dut1 (
    .clk(clk), .rst(rst),
    .in_proto_hdr_valid(p1_valid), .in_proto_hdr_ready(p1_ready),
    .in_proto_hdr_length(p1_len), .in_proto_hdr_data(p1_data), .in_proto_hdr_phv(p1_phv),
    .cfg_port_enable(p1_enable), .cfg_cnt_clear(clear),
    .out_proto_hdr_valid(p1_out_valid), .out_proto_hdr_ready(p1_out_ready),
    .out_proto_hdr_data(p1_out_data), .out_proto_hdr_phv(p1_out_phv),
    .out_proto_hdr_length(p1_out_len), .out_proto_hdr_src(p1_out_src),
    .stat_accept_cnt(p1_stat)
  );

  typedef struct {
    logic [1:0]     src;
    logic [HW-1:0]  data;
    logic [PHW-1:0] phv;
    logic [15:0]    len;
  } beat_t;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] enable;
    logic       out_ready;
    logic       clear;
    logic [3:0] exp_in_ready;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs [0:14];

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  int m_ptr = 0;
  bit m_valid = 1'b0;
  int m_cnt [P];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic set_payloads();
    for (int i = 0; i < P; i++) begin
      in_data[i*HW +: HW]   = {32'(i + 1), 32'(cyc_n)};
      in_phv[i*PHW +: PHW]  = 16'(cyc_n * 4 + i) ^ 16'hBEEF;
      in_len[i*16 +: 16]    = 16'(100 * i + cyc_n);
    end
  endtask

  task automatic check_cnts(input string name);
    for (int i = 0; i < P; i++) check(name, 64'(stat[i*CW +: CW]), 64'(m_cnt[i]));
  endtask

  // One clock cycle. The task predicts ready and the output beat, updates
  // the scoreboard, then advances to 1 time unit after the next rising edge.
  task automatic cycle();
    logic [3:0] req, exp_rdy;
    int         g, p;
    bit         can_load;
    beat_t      b;
    set_payloads();
    #1;
    req = in_valid & enable;
    g = -1;
    for (int k = 0; k < P; k++) begin
      p = (m_ptr + k) % P;
      if (g < 0 && req[p]) g = p;
    end
    can_load = !m_valid || out_ready;
    exp_rdy = '0;
    if (g >= 0 && can_load && !rst) exp_rdy[g] = 1'b1;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 64'(exp_q.size()), 64'd1);
      end else begin
        check("out_src", 64'(out_src), 64'(exp_q[0].src));
        check("out_data", out_data, exp_q[0].data);
        check("out_phv", 64'(out_phv), 64'(exp_q[0].phv));
        check("out_len", 64'(out_len), 64'(exp_q[0].len));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (exp_rdy != 0) begin
      b.src  = 2'(g);
      b.data = in_data[g*HW +: HW];
      b.phv  = in_phv[g*PHW +: PHW];
      b.len  = in_len[g*16 +: 16];
      exp_q.push_back(b);
    end
    for (int i = 0; i < P; i++) begin
      if (clear) m_cnt[i] = 0;
      else if (exp_rdy[i]) m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
    end
    if (rst) begin
      m_valid = 1'b0;
      m_ptr = 0;
      exp_q.delete();
      for (int i = 0; i < P; i++) m_cnt[i] = 0;
    end else if (exp_rdy != 0) begin
      m_valid = 1'b1;
      m_ptr = (g + 1) % P;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_row(input int i);
    in_valid  = vecs[i].valid;
    enable    = vecs[i].enable;
    out_ready = vecs[i].out_ready;
    clear     = vecs[i].clear;
    #1;
    check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_in_ready));
    cycle();
  endtask

  logic [HW-1:0] held_data;

  initial begin
    // Rows 0-7: all ports requesting, fair rotation from pointer 0.
    // Row 8: idle + counter clear. Rows 9-14: port 2 masked off.
    vecs[0]  = '{4'hF, 4'hF, 1'b1, 1'b0, 4'b0001};
    vecs[1]  = '{4'hF, 4'hF, 1'b1, 1'b0, 4'b0010};
    vecs[2]  = '{4'hF, 4'hF, 1'b1, 1'b0, 4'b0100};
    vecs[3]  = '{4'hF, 4'hF, 1'b1, 1'b0, 4'b1000};
    vecs[4]  = '{4'hF, 4'hF, 1'b1, 1'b0, 4'b0001};
    vecs[5]  = '{4'hF, 4'hF, 1'b1, 1'b0, 4'b0010};
    vecs[6]  = '{4'hF, 4'hF, 1'b1, 1'b0, 4'b0100};
    vecs[7]  = '{4'hF, 4'hF, 1'b1, 1'b0, 4'b1000};
    vecs[8]  = '{4'h0, 4'hF, 1'b1, 1'b1, 4'b0000};
    vecs[9]  = '{4'hF, 4'hB, 1'b1, 1'b0, 4'b0001};
    vecs[10] = '{4'hF, 4'hB, 1'b1, 1'b0, 4'b0010};
    vecs[11] = '{4'hF, 4'hB, 1'b1, 1'b0, 4'b1000};
    vecs[12] = '{4'hF, 4'hB, 1'b1, 1'b0, 4'b0001};
    vecs[13] = '{4'hF, 4'hB, 1'b1, 1'b0, 4'b0010};
    vecs[14] = '{4'hF, 4'hB, 1'b1, 1'b0, 4'b1000};

    for (int i = 0; i < P; i++) m_cnt[i] = 0;
    rst = 1'b1; in_valid = '0; enable = 4'hF; out_ready = 1'b1; clear = 1'b0;
    p1_valid = 1'b0; p1_enable = 1'b1; p1_out_ready = 1'b1;
    p1_len = '0; p1_data = '0; p1_phv = '0;
    set_payloads();
    @(posedge clk); #1;

    // Reset state: ready stays low even with a valid request present.
    in_valid = 4'b0001;
    cycle();
    check("rst_cnt", 64'(stat), 64'd0);
    rst = 1'b0;
    cycle();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_src", 64'(out_src), 64'd0);
    in_valid = '0;
    cycle();
    rst = 1'b1; cycle(); rst = 1'b0;

    // Rotation and masking from the table.
    for (int i = 0; i <= 7; i++) apply_row(i);
    check("t2_cnt", 64'(stat), 64'h2222);
    check_cnts("t2_cnt_model");
    for (int i = 8; i <= 14; i++) apply_row(i);
    check("t4_cnt", 64'(stat), 64'h2022);

    // Stall: port 1 granted, then 5 cycles of out_ready=0.
    enable = 4'hF; clear = 1'b0; in_valid = '0; out_ready = 1'b1;
    cycle();
    in_valid = 4'b1010;
    cycle();
    held_data = out_data;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t3_src_held", 64'(out_src), 64'd1);
      check("t3_data_held", out_data, held_data);
    end
    out_ready = 1'b1;
    cycle();
    check("t3_next_src", 64'(out_src), 64'd3);
    in_valid = '0;
    cycle();

    // Counter wrap at 4 bits, then clear with a same-cycle accept.
    rst = 1'b1; cycle(); rst = 1'b0;
    in_valid = 4'b0001;
    for (int i = 0; i < 17; i++) cycle();
    check("t5_wrap", 64'(stat[3:0]), 64'd1);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check("t5_clr", 64'(stat[3:0]), 64'd0);
    in_valid = '0;
    cycle();
    check_cnts("t5_cnt_model");

    // Reset while a beat is stalled in the output register.
    in_valid = 4'b0001; out_ready = 1'b0;
    cycle();
    check("t6_pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1; in_valid = '0;
    cycle();
    rst = 1'b0;
    check("t6_valid", 64'(out_valid), 64'd0);
    in_valid = 4'hF; out_ready = 1'b1;
    #1;
    check("t6_ptr", 64'(in_ready), 64'b0001);
    cycle();
    in_valid = '0;
    cycle();
    cycle();

    // Single-port instance: source index is always 0.
    p1_data = 64'hDEAD_BEEF_0123_4567; p1_phv = 16'h5A5A; p1_len = 16'd77;
    p1_valid = 1'b1;
    #1;
    check("p1_ready", 64'(p1_ready), 64'd1);
    @(posedge clk); #1;
    p1_valid = 1'b0;
    check("p1_valid", 64'(p1_out_valid), 64'd1);
    check("p1_src", 64'(p1_out_src), 64'd0);
    check("p1_data", p1_out_data, 64'hDEAD_BEEF_0123_4567);
    check("p1_len", 64'(p1_out_len), 64'd77);
    check("p1_cnt", 64'(p1_stat), 64'd1);
    p1_enable = 1'b0; p1_valid = 1'b1;
    #1;
    check("p1_masked", 64'(p1_ready), 64'd0);
    p1_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
